// File: rtl/cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares the single-port monitor RAM between the JTAG
// debug path (monitor address/data registers) and the CPU-side Avalon-MM
// debug slave. Every access passes through IDLE, so grants are never
// back-to-back.
module cpu_ocimem_arbiter #(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'h80,
  parameter bit              JTAG_FAIR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_we,
  input  logic [31:0]       jtag_wdata,
  output logic [31:0]       jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_overrun,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, JWR, JRD, JCAP, AWR, ARD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mon_addr;
  logic              pend;
  logic              pend_we;
  logic [31:0]       pend_wdata;
  logic              last_jtag;
  logic              done_p1;
  logic              rdv_p1;
  logic [31:0]       mon_data;
  logic              jtag_grant;
  logic              jtag_finish;
  logic              prot_hit;

  // JTAG wins when it is pending and either fairness is off, it is JTAG's turn,
  // or Avalon is not asking at all.
  assign jtag_grant  = pend && (!JTAG_FAIR || !last_jtag || !(avs_read || avs_write));
  assign jtag_finish = (state == JWR) || (state == JCAP);
  assign prot_hit    = (avs_address >= PROT_BASE) && !debugack;

  assign jtag_done         = done_p1;
  assign jtag_rdata        = mon_data;
  assign avs_readdatavalid = rdv_p1;
  // RAM data is only meaningful in the cycle after an Avalon read grant.
  assign avs_readdata      = rdv_p1 ? ram_rdata : 32'h0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: grant decisions happen only from IDLE; every access returns there.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (jtag_grant)     state_nxt = pend_we ? JWR : JRD;
        else if (avs_write) state_nxt = AWR;
        else if (avs_read)  state_nxt = ARD;
        else                state_nxt = IDLE;
      end
      JRD:     state_nxt = JCAP;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port and Avalon handshake driven from the current state.
  always_comb begin
    ram_addr        = '0;
    ram_wdata       = 32'h0;
    ram_be          = 4'h0;
    ram_we          = 1'b0;
    avs_waitrequest = 1'b1;
    case (state)
      JWR: begin
        ram_addr  = mon_addr;
        ram_wdata = pend_wdata;
        ram_be    = 4'hF;
        ram_we    = 1'b1;
      end
      JRD: ram_addr = mon_addr;
      AWR: begin
        ram_addr        = avs_address;
        ram_wdata       = avs_writedata;
        ram_be          = avs_byteenable;
        ram_we          = !prot_hit;
        avs_waitrequest = 1'b0;
      end
      ARD: begin
        ram_addr        = avs_address;
        avs_waitrequest = 1'b0;
      end
      default: ;
    endcase
  end

  // JTAG request bookkeeping, monitor address/data, completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_addr  <= '0;
      pend      <= 1'b0;
      last_jtag <= 1'b0;
      done_p1   <= 1'b0;
      rdv_p1    <= 1'b0;
      mon_data  <= 32'h0;
      jtag_overrun <= 1'b0;
    end else begin
      // ---- stage p1: completion pulses one cycle after the access state
      done_p1 <= jtag_finish;
      rdv_p1  <= (state == ARD);
      if (state == JCAP) mon_data <= ram_rdata;
      if (state == IDLE && state_nxt != IDLE)
        last_jtag <= (state_nxt == JWR) || (state_nxt == JRD);
      // A load always beats the post-access increment.
      if (jtag_addr_load)   mon_addr <= jtag_addr;
      else if (jtag_finish) mon_addr <= mon_addr + 1'b1;
      if (jtag_finish) pend <= 1'b0;
      if (jtag_req) begin
        if (pend) jtag_overrun <= 1'b1;
        else      pend         <= 1'b1;
      end
    end
  end

  // Request payload is captured only when a request is actually taken.
  always_ff @(posedge clk) begin
    if (jtag_req && !pend) begin
      pend_we    <= jtag_we;
      pend_wdata <= jtag_wdata;
    end
  end

endmodule

// File: doc/cpu_ocimem_arbiter.md
Name: cpu_ocimem_arbiter

Overview:
- Sequences and shares the Nios II on-chip debug memory (OCI RAM, single-port, 32-bit words) between two requesters: the JTAG debug path (sysclk-side take_action strobes plus jdo payload) and the CPU-side Avalon-MM debug slave.
- Sits between the debug-module sysclk decoder and the OCI RAM instance inside the cpu block.
- Owns the auto-incrementing monitor address register and the monitor data register returned to JTAG.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- PROT_BASE, 8'h80, first word address write-protected from Avalon while debugack=0.
- JTAG_FAIR, 1, 1 = round-robin between the two requesters; 0 = JTAG always wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- debugack  in  1  CPU is halted in debug mode.
- jtag_addr_load  in  1  1-cycle strobe: load monitor address from jtag_addr.
- jtag_addr  in  ADDR_W  address payload (from jdo).
- jtag_req  in  1  1-cycle strobe: perform one access at the monitor address.
- jtag_we  in  1  qualifies jtag_req: 1 = write, 0 = read.
- jtag_wdata  in  32  write data (from jdo).
- jtag_rdata  out  32  monitor data register (MonDReg).
- jtag_done  out  1  1-cycle pulse when the JTAG access completes.
- jtag_overrun  out  1  sticky flag: jtag_req arrived while a JTAG access was still pending.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write.
- avs_address  in  ADDR_W  Avalon word address.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  Avalon byte enables.
- avs_waitrequest  out  1  Avalon stall.
- avs_readdata  out  32  Avalon read data.
- avs_readdatavalid  out  1  Avalon read data valid.
- ram_addr  out  ADDR_W  OCI RAM address.
- ram_wdata  out  32  OCI RAM write data.
- ram_be  out  4  OCI RAM byte enables.
- ram_we  out  1  OCI RAM write enable.
- ram_rdata  in  32  OCI RAM read data; 1-cycle registered latency.

Behaviour:
- Reset values: all outputs 0 except avs_waitrequest=1. Monitor address = 0, jtag pending flag = 0, last_grant = AVS, state = IDLE.
- jtag_addr_load: the monitor address takes jtag_addr on the next edge. If it coincides with jtag_req, the load applies first and the access uses the new address.
- jtag_req: sets the pending flag and latches jtag_we/jtag_wdata. If the flag is already set, the request is dropped, jtag_overrun is set, and the flag stays set. jtag_overrun clears only on reset.
- States: IDLE, JWR, JRD, JCAP, AWR, ARD.
- IDLE grant rule:
  - JTAG is granted if pending and (JTAG_FAIR=0, or last_grant=AVS, or no Avalon request).
  - Otherwise Avalon is granted if avs_read or avs_write is asserted.
  - If both avs_read and avs_write are asserted, the write wins.
- JWR (1 cycle): ram_we=1, ram_be=4'hF, ram_addr = monitor address. Next state IDLE. jtag_done pulses in that IDLE cycle; monitor address increments (wraps modulo 2^ADDR_W); pending clears.
- JRD (1 cycle): ram_addr = monitor address, ram_we=0, then JCAP.
- JCAP (1 cycle): jtag_rdata <= ram_rdata, jtag_done pulses next cycle, address increments, pending clears. Next state IDLE.
- JTAG latency, jtag_req to jtag_done, uncontended: write 3 cycles, read 4 cycles.
- AWR / ARD grant cycle: avs_waitrequest=0 for exactly one cycle; the transaction is accepted in that cycle.
  - AWR: drives ram_we=1 with avs_byteenable.
  - AWR protection: write suppressed (ram_we=0) when avs_address >= PROT_BASE and debugack=0; the transfer is still accepted.
- ARD: drives ram_addr; avs_readdatavalid=1 on the following cycle with avs_readdata = ram_rdata.
- After any grant, last_grant is updated.
- avs_waitrequest is 1 in every cycle other than an Avalon grant cycle.
- No back-to-back grants: at least one IDLE cycle between accesses.
- Reset mid-operation: the in-flight access is abandoned; no jtag_done or readdatavalid is issued after reset.

Test Plan:
- Load addr 8'h10, jtag write 32'hDEADBEEF -> ram_we at addr 8'h10, jtag_done 3 cycles after req, monitor addr = 8'h11.
- Load addr 8'h10, jtag read with RAM holding 32'hCAFEF00D -> jtag_rdata=32'hCAFEF00D, jtag_done 4 cycles after req, addr=8'h11.
- Addr 8'hFF, jtag write -> address wraps to 8'h00.
- Avalon read held continuously while jtag_req pulses every 6 cycles, JTAG_FAIR=1 -> grants alternate; each waitrequest-low cycle is followed by readdatavalid=1.
- Avalon write to 8'h90 with debugack=0 -> accepted, ram_we=0. Same write with debugack=1 -> ram_we=1, ram_be = avs_byteenable.
- Second jtag_req before jtag_done -> jtag_overrun=1, exactly one jtag_done. Assert reset in JRD -> no jtag_done, avs_waitrequest=1, all other outputs 0.
